nem_ohmux_sel_ctrl: RTL
=======================

NEM_OHMUX_SEL_CTRL -- requirements
Module: nem_ohmux_sel_ctrl

Interface
REQ-001 Parameter T_REL, default 8, release-settle cycles: all selects low before a new select is driven (legal 1..255).
REQ-002 Parameter T_PULL, default 16, pull-in settle cycles after a select is driven (legal 1..255).
REQ-003 Single clock and asynchronous, active-high reset.
REQ-004 CP  input  1  clock; all state updates on rising edge.
REQ-005 CD  input  1  asynchronous active-high reset.
REQ-006 REQ_VALID  input  1  requester presents a select command.
REQ-007 REQ_SEL  input  2  target mux input index 0..3.
REQ-008 REQ_OFF  input  1  command releases all selects; REQ_SEL ignored.
REQ-009 REQ_READY  output  1  controller accepts a command this cycle.
REQ-010 S0, S1, S2, S3  output  1 each  one-hot relay selects to the 4-input mux.
REQ-011 BUSY  output  1  switching sequence in progress.
REQ-012 SETTLED  output  1  a select is driven and its pull-in time has elapsed.

Function
REQ-013 States: IDLE, RELEASE, PULLIN; REQ_READY=1 only in IDLE.
REQ-014 Command accepted on a rising CP edge with REQ_VALID=1 and REQ_READY=1; REQ_SEL/REQ_OFF are sampled on that edge.
REQ-015 Accepted command equal to the current driven select: no transition, S unchanged, state stays IDLE; the command completes in 0 extra cycles.
REQ-016 Any other accepted command: next cycle S0..S3 = 0, state RELEASE, counter loaded T_REL.
REQ-017 RELEASE after T_REL cycles: REQ_OFF command goes to IDLE with S all 0; otherwise the target S is driven high and the FSM enters PULLIN with counter loaded T_PULL.
REQ-018 PULLIN after T_PULL cycles goes to IDLE; SETTLED rises with the IDLE entry.
REQ-019 Latency for a switch accepted at edge n: S drop at n+1, new S rise at n+1+T_REL, SETTLED at n+1+T_REL+T_PULL.
REQ-020 S0..S3 are never more than one-hot at any cycle, including during and after reset (break-before-make).
REQ-021 BUSY = (state != IDLE); SETTLED = IDLE and one S high.
REQ-022 REQ_VALID held while BUSY: no effect; the command is accepted on the first IDLE cycle.
REQ-023 REQ_OFF with S already all 0: treated per REQ-015 (no-op).
REQ-024 Counter is a width-8 down-counter; it never wraps, and terminal count is detected at 1.

Reset
REQ-025 CD asserted at any time, including mid-RELEASE/PULLIN: S0..S3=0, state IDLE, counter 0, BUSY=0, SETTLED=0, REQ_READY=1 after deassertion.
REQ-026 The first command after reset always takes the full RELEASE+PULLIN sequence unless it is REQ_OFF.

Configuration
REQ-027 Macro NEM_OHMUX_WEAR_CNT_EN defined: output port PULL_CNT (4x16 bits, entry i counts S_i pull-in events), saturating at 16'hFFFF, cleared by CD.
REQ-028 Macro absent: no PULL_CNT port and no counter logic; all other behaviour is identical.

Structure
REQ-029 Package nem_ohmux_pkg holds the state enum, SEL_W=2, N_IN=4, CNT_W=8, and the T_REL/T_PULL defaults.
REQ-030 Sub-module nem_ohmux_dly_cnt: loadable down-counter with a done flag, instantiated once.

Verification
REQ-031 Reset, then sel=2 accepted at edge n (T_REL=8, T_PULL=16) -> S all 0 through n+8, S2=1 at n+9, SETTLED=1 at n+25.
REQ-032 Settled on S2, request sel=2 -> REQ_READY stays 1, no S toggle, BUSY stays 0.
REQ-033 Settled on S1, request sel=3 -> S1 falls at n+1, S3 rises at n+9, no cycle has two S high.
REQ-034 CD pulsed during PULLIN of S0 -> S0 falls asynchronously, BUSY=0, next sel=0 request runs the full sequence.
REQ-035 Settled on S3, REQ_OFF -> S3 falls at n+1, IDLE at n+9, SETTLED=0; with NEM_OHMUX_WEAR_CNT_EN, PULL_CNT[3] equals the count of S3 rises.
REQ-036 REQ_VALID held with sel=1 during BUSY -> accepted exactly once on the first IDLE cycle.

Source files
------------

// File: rtl/nem_ohmux_pkg.sv
// Shared types and constants for the NEM relay one-hot mux select controller.
// Optional feature macro: NEM_OHMUX_WEAR_CNT_EN (per-input pull-in wear counters).
package nem_ohmux_pkg;

  localparam int SEL_W      = 2;
  localparam int N_IN       = 4;
  localparam int CNT_W      = 8;
  localparam int WEAR_W     = 16;
  localparam int T_REL_DEF  = 8;
  localparam int T_PULL_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_PULLIN  = 2'd2
  } state_e;

  // Command captured on acceptance; sel is don't-care when off is set.
  typedef struct packed {
    logic             off;
    logic [SEL_W-1:0] sel;
  } cmd_t;

  function automatic logic [N_IN-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return N_IN'(1) << sel;
  endfunction

endpackage

// File: rtl/nem_ohmux_dly_cnt.sv
// Loadable 8-bit settle-time down-counter. Stops at zero (never wraps);
// done flags the terminal count of 1 so the FSM moves on the following edge.
module nem_ohmux_dly_cnt
  import nem_ohmux_pkg::*;
(
  input  logic             gclk,
  input  logic             grst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst)            cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select sequencer for a 4-input NEM relay mux.
// A new select first releases all relays for T_REL cycles, then drives the
// target and waits T_PULL cycles for pull-in before reporting SETTLED.
// Optional feature macro: NEM_OHMUX_WEAR_CNT_EN adds PULL_CNT wear counters.
module nem_ohmux_sel_ctrl
  import nem_ohmux_pkg::*;
#(
  parameter int T_REL  = T_REL_DEF,
  parameter int T_PULL = T_PULL_DEF
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             REQ_VALID,
  input  logic [SEL_W-1:0] REQ_SEL,
  input  logic             REQ_OFF,
  output logic             REQ_READY,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic             BUSY,
  output logic             SETTLED
`ifdef NEM_OHMUX_WEAR_CNT_EN
  ,
  output logic [N_IN-1:0][WEAR_W-1:0] PULL_CNT
`endif
);

  state_e           state;
  logic [N_IN-1:0]  s_q;
  cmd_t             cmd_q;
  logic             accept;
  logic             noop;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             pull_ev;

  assign accept  = REQ_VALID && (state == ST_IDLE);
  // Request already satisfied: same select driven, or release with nothing driven.
  assign noop    = REQ_OFF ? (s_q == '0) : s_q[REQ_SEL];
  // A relay gets driven at the end of the release window unless this is a release-only command.
  assign pull_ev = (state == ST_RELEASE) && cnt_done && !cmd_q.off;

  // Counter load: release window on a real switch, pull-in window when a relay gets driven.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (accept && !noop) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(T_REL);
    end else if (pull_ev) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(T_PULL);
    end
  end

  nem_ohmux_dly_cnt u_dly (
    .gclk     (CP),
    .grst     (CD),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Sequencer FSM; s_q only ever holds zero or a single bit, so the relays never overlap.
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state <= ST_IDLE;
      s_q   <= '0;
      cmd_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !noop) begin
            cmd_q <= '{off: REQ_OFF, sel: REQ_SEL};
            s_q   <= '0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_done) begin
            if (cmd_q.off) begin
              state <= ST_IDLE;
            end else begin
              s_q   <= sel_onehot(cmd_q.sel);
              state <= ST_PULLIN;
            end
          end
        end
        ST_PULLIN: begin
          if (cnt_done) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          s_q   <= '0;
        end
      endcase
    end
  end

  assign REQ_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign SETTLED   = (state == ST_IDLE) && (s_q != '0);
  assign S0        = s_q[0];
  assign S1        = s_q[1];
  assign S2        = s_q[2];
  assign S3        = s_q[3];

`ifdef NEM_OHMUX_WEAR_CNT_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_wear
    // Count pull-in events of relay i, saturating at all-ones.
    always_ff @(posedge CP or posedge CD) begin
      if (CD)
        PULL_CNT[i] <= '0;
      else if (pull_ev && (cmd_q.sel == SEL_W'(i)) && (PULL_CNT[i] != '1))
        PULL_CNT[i] <= PULL_CNT[i] + WEAR_W'(1);
    end
  end
`endif

endmodule
